// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encoding, miss-count width
// and the saturating increment used by the misprediction counter.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } ctr_state_t;

    localparam int MISPRED_CNT_W = 16;

    function automatic logic [MISPRED_CNT_W-1:0] sat_inc_cnt(input logic [MISPRED_CNT_W-1:0] c);
        return (c == {MISPRED_CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// One 2-bit saturating direction counter. Allocation forces weakly-taken and
// takes priority over a train update.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       upd_en,
    input  logic       upd_taken,
    input  logic       alloc,
    output logic [1:0] ctr
);

    ctr_state_t ctr_reg;
    ctr_state_t ctr_next;
    logic [1:0] ctr_plus;
    logic [1:0] ctr_minus;

    assign ctr_plus  = ctr_reg + 2'd1;
    assign ctr_minus = ctr_reg - 2'd1;

    always_comb begin
        ctr_next = ctr_reg;
        if (alloc) begin
            ctr_next = CTR_WT;
        end else if (upd_en) begin
            if (upd_taken && ctr_reg != CTR_ST) begin
                ctr_next = ctr_state_t'(ctr_plus);
            end else if (!upd_taken && ctr_reg != CTR_SNT) begin
                ctr_next = ctr_state_t'(ctr_minus);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctr_reg <= CTR_WNT;
        end else begin
            ctr_reg <= ctr_next;
        end
    end

    assign ctr = ctr_reg;

endmodule

// File: rtl/branch_predictor.sv
// Tagged direct-mapped branch predictor with 2-bit counters and stored targets.
// Table is held in flops so one reset cycle clears it; lookups see pre-update state.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAGW    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pred_req,
    input  logic [31:0] pred_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    output logic        mispredict,
    output logic [15:0] mispred_cnt
);

    localparam int IDX = $clog2(ENTRIES);

    logic              valid_reg  [ENTRIES];
    logic [TAGW-1:0]   tag_reg    [ENTRIES];
    logic [31:0]       target_reg [ENTRIES];
    logic [2*ENTRIES-1:0] ctr_flat;

    logic [IDX-1:0]  lk_idx;
    logic [IDX-1:0]  up_idx;
    logic [TAGW-1:0] lk_tag;
    logic [TAGW-1:0] up_tag;
    logic            lk_hit;
    logic            lk_taken;
    logic            up_hit;
    logic            up_train;
    logic            up_alloc;
    logic            mis_evt;

    logic                     pred_valid_reg;
    logic                     pred_taken_reg;
    logic [31:0]              pred_target_reg;
    logic                     mispredict_reg;
    logic [MISPRED_CNT_W-1:0] mispred_cnt_reg;

    assign lk_idx = pred_pc[IDX+1:2];
    assign lk_tag = pred_pc[IDX+1+TAGW:IDX+2];
    assign up_idx = upd_pc[IDX+1:2];
    assign up_tag = upd_pc[IDX+1+TAGW:IDX+2];

    assign lk_hit   = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && ctr_flat[{lk_idx, 1'b1}];

    assign up_hit   = valid_reg[up_idx] && (tag_reg[up_idx] == up_tag);
    assign up_train = upd_valid && up_hit;
    assign up_alloc = upd_valid && !up_hit && upd_taken;
    assign mis_evt  = upd_valid && (upd_taken != upd_pred_taken);

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic sel;
            assign sel = (up_idx == IDX'(gi));

            sat_counter2 u_ctr (
                .clk       (clk),
                .rst_n     (rst_n),
                .upd_en    (sel && up_train),
                .upd_taken (upd_taken),
                .alloc     (sel && up_alloc),
                .ctr       (ctr_flat[2*gi +: 2])
            );
        end
    endgenerate

    // Valid/tag/target state; a hit only rewrites the target when taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i]  <= 1'b0;
                tag_reg[i]    <= '0;
                target_reg[i] <= '0;
            end
        end else if (up_alloc) begin
            valid_reg[up_idx]  <= 1'b1;
            tag_reg[up_idx]    <= up_tag;
            target_reg[up_idx] <= upd_target;
        end else if (up_train && upd_taken) begin
            target_reg[up_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_valid_reg  <= 1'b0;
            pred_taken_reg  <= 1'b0;
            pred_target_reg <= '0;
            mispredict_reg  <= 1'b0;
            mispred_cnt_reg <= '0;
        end else begin
            pred_valid_reg  <= pred_req;
            pred_taken_reg  <= pred_req && lk_taken;
            pred_target_reg <= (pred_req && lk_taken) ? target_reg[lk_idx] : 32'd0;
            mispredict_reg  <= mis_evt;
            if (mis_evt) begin
                mispred_cnt_reg <= sat_inc_cnt(mispred_cnt_reg);
            end
        end
    end

    assign pred_valid  = pred_valid_reg;
    assign pred_taken  = pred_taken_reg;
    assign pred_target = pred_target_reg;
    assign mispredict  = mispredict_reg;
    assign mispred_cnt = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a reference table predicts every cycle's
// outputs, which are queued at drive time and popped after the clock edge.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic        mispredict;
    logic [15:0] mispred_cnt;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(64), .TAGW(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pred_req       (pred_req),
        .pred_pc        (pred_pc),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .mispredict     (mispredict),
        .mispred_cnt    (mispred_cnt)
    );

    typedef struct {
        logic        pv;
        logic        pt;
        logic [31:0] tg;
        logic        mis;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    // Reference table: 64 entries, index pc[7:2], tag pc[15:8]
    logic        m_valid [64];
    logic [7:0]  m_tag   [64];
    logic [1:0]  m_ctr   [64];
    logic [31:0] m_tgt   [64];
    logic [15:0] m_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulse  = 0;
    int cyc      = 0;

    logic        obs_taken;
    logic [31:0] obs_target;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 8'd0;
            m_ctr[i]   = 2'd1;
            m_tgt[i]   = 32'd0;
        end
        m_cnt = 16'd0;
    endtask

    task automatic step(input logic r, input logic req, input logic [31:0] pc,
                        input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utg, input logic upt);
        exp_t e;
        exp_t g;
        int li, ui;
        logic hit;
        rst_n = r; pred_req = req; pred_pc = pc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg; upd_pred_taken = upt;
        if (!r) begin
            model_reset();
            e = '{pv: 1'b0, pt: 1'b0, tg: 32'd0, mis: 1'b0, cnt: 16'd0};
        end else begin
            li = int'(pc[7:2]);
            hit = m_valid[li] && m_tag[li] == pc[15:8];
            e.pv  = req;
            e.pt  = req && hit && m_ctr[li][1];
            e.tg  = e.pt ? m_tgt[li] : 32'd0;
            e.mis = uv && (ut != upt);
            if (e.mis && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            e.cnt = m_cnt;
            ui = int'(upc[7:2]);
            if (uv) begin
                if (m_valid[ui] && m_tag[ui] == upc[15:8]) begin
                    if (ut) begin
                        if (m_ctr[ui] != 2'd3) m_ctr[ui] = m_ctr[ui] + 2'd1;
                        m_tgt[ui] = utg;
                    end else if (m_ctr[ui] != 2'd0) begin
                        m_ctr[ui] = m_ctr[ui] - 2'd1;
                    end
                end else if (ut) begin
                    m_valid[ui] = 1'b1;
                    m_tag[ui]   = upc[15:8];
                    m_ctr[ui]   = 2'd2;
                    m_tgt[ui]   = utg;
                end
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            g = sb_q.pop_front();
            check_val("pred_valid", {31'd0, pred_valid}, {31'd0, g.pv});
            check_val("pred_taken", {31'd0, pred_taken}, {31'd0, g.pt});
            check_val("pred_target", pred_target, g.tg);
            check_val("mispredict", {31'd0, mispredict}, {31'd0, g.mis});
            check_val("mispred_cnt", {16'd0, mispred_cnt}, {16'd0, g.cnt});
        end
        if (mispredict === 1'b1) n_pulse++;
        obs_taken  = pred_taken;
        obs_target = pred_target;
        $display("cyc %0d rst_n=%b req=%b pc=%h upd=%b upc=%h t=%b -> pv=%b pt=%b tg=%h mis=%b cnt=%0d",
                 cyc, r, req, pc, uv, upc, ut, pred_valid, pred_taken, pred_target, mispredict, mispred_cnt);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic lookup(input logic [31:0] pc);
        step(1'b1, 1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tg, input logic pt);
        step(1'b1, 1'b0, 32'd0, 1'b1, pc, t, tg, pt);
    endtask

    logic [31:0] pc_pool [6];

    initial begin
        pc_pool[0] = 32'h100;  pc_pool[1] = 32'h1100; pc_pool[2] = 32'h200;
        pc_pool[3] = 32'h104;  pc_pool[4] = 32'h3F0;  pc_pool[5] = 32'h0010_0104;

        // Reset with garbage on inputs, which must be ignored
        step(1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        check_val("reset_cnt", {16'd0, mispred_cnt}, 32'd0);
        idle();
        check_val("post_reset_pv", {31'd0, pred_valid}, 32'd0);

        lookup(32'h100);
        check_val("req34_taken", {31'd0, obs_taken}, 32'd0);
        check_val("req34_target", obs_target, 32'd0);

        update(32'h100, 1'b1, 32'h80, 1'b0);
        lookup(32'h100);
        check_val("req35_taken", {31'd0, obs_taken}, 32'd1);
        check_val("req35_target", obs_target, 32'h80);

        update(32'h100, 1'b0, 32'd0, 1'b1);
        update(32'h100, 1'b0, 32'd0, 1'b1);
        lookup(32'h100);
        check_val("req36_taken", {31'd0, obs_taken}, 32'd0);
        update(32'h100, 1'b0, 32'd0, 1'b0);
        update(32'h100, 1'b1, 32'h80, 1'b0);
        lookup(32'h100);
        check_val("req36_sat0", {31'd0, obs_taken}, 32'd0);

        update(32'h100, 1'b1, 32'h80, 1'b0);
        update(32'h1100, 1'b1, 32'h44, 1'b0);
        lookup(32'h100);
        check_val("req37_miss", {31'd0, obs_taken}, 32'd0);
        lookup(32'h1100);
        check_val("req37_new_tgt", obs_target, 32'h44);

        step(1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0);
        check_val("req38_rbw", {31'd0, obs_taken}, 32'd0);
        lookup(32'h200);
        check_val("req38_next", {31'd0, obs_taken}, 32'd1);

        // Three mispredictions from a clean counter
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        n_pulse = 0;
        update(32'h300, 1'b0, 32'd0, 1'b1);
        update(32'h300, 1'b1, 32'h10, 1'b0);
        update(32'h300, 1'b0, 32'd0, 1'b1);
        idle();
        check_val("req39_pulses", n_pulse, 32'd3);
        check_val("req39_cnt", {16'd0, mispred_cnt}, 32'd3);
        step(1'b0, 1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 32'h0, 1'b0);
        check_val("req39_clear", {16'd0, mispred_cnt}, 32'd0);

        // Pending lookup aborted by reset
        lookup(32'h300);
        step(1'b0, 1'b1, 32'h300, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        idle();

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) != 0),
                 1'($urandom_range(0, 1)), pc_pool[$urandom_range(0, 5)],
                 1'($urandom_range(0, 1)), pc_pool[$urandom_range(0, 5)],
                 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end

        check_val("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of table entries (power of two, 4..256).
REQ-002 SHALL have parameter TAGW, default 8, number of tag bits stored per entry.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port pred_req, input, 1, fetch lookup request this cycle.
REQ-006 SHALL have port pred_pc, input, 32, fetch PC to look up.
REQ-007 SHALL have port pred_valid, output, 1, response to the previous cycle's pred_req.
REQ-008 SHALL have port pred_taken, output, 1, predicted direction.
REQ-009 SHALL have port pred_target, output, 32, predicted target; zero when pred_taken=0.
REQ-010 SHALL have port upd_valid, input, 1, resolved conditional branch outcome present.
REQ-011 SHALL have port upd_pc, input, 32, PC of the resolved branch.
REQ-012 SHALL have port upd_taken, input, 1, resolved direction (branch-compare select).
REQ-013 SHALL have port upd_target, input, 32, resolved taken target.
REQ-014 SHALL have port upd_pred_taken, input, 1, direction predicted earlier for this branch.
REQ-015 SHALL have port mispredict, output, 1, registered flag: previous cycle's update disagreed with its prediction.
REQ-016 SHALL have port mispred_cnt, output, 16, saturating count of mispredictions.

Function
REQ-017 SHALL index entries with IDX=log2(ENTRIES) bits pc[IDX+1:2]; tag = pc[IDX+1+TAGW:IDX+2].
REQ-018 Each entry SHALL hold valid (1b), tag (TAGW), 2-bit saturating counter, target (32b).
REQ-019 Lookup latency SHALL be one cycle: pred_req at cycle N gives pred_valid=1 at N+1, else pred_valid=0.
REQ-020 pred_taken SHALL be 1 only if the entry is valid, the tag matches, and counter[1]=1.
REQ-021 On a hit with pred_taken=1, pred_target SHALL equal the stored target; otherwise 0.
REQ-022 On upd_valid with a tag hit, the counter SHALL increment on taken and decrement on not-taken, saturating at 3 and 0; the target SHALL be overwritten when taken.
REQ-023 On upd_valid with a miss and upd_taken=1, the entry SHALL be allocated (replaced): valid=1, new tag, counter=2, target=upd_target.
REQ-024 On upd_valid with a miss and upd_taken=0, the table SHALL be unchanged.
REQ-025 When lookup and update target the same index in the same cycle, the lookup SHALL return the pre-update state (read-before-write).
REQ-026 mispredict SHALL be 1 in cycle N+1 iff upd_valid at N and upd_taken != upd_pred_taken.
REQ-027 mispred_cnt SHALL increment on each mispredict and hold at 16'hFFFF.
REQ-028 Inputs while rst_n=0 SHALL be ignored.

Reset
REQ-029 While rst_n=0 at a clock edge, all valid bits, pred_valid, pred_taken, pred_target, mispredict and mispred_cnt SHALL become 0; all counters SHALL become 1 (weakly not-taken).
REQ-030 Reset asserted mid-operation SHALL abort any pending response; the cycle after reset deasserts, pred_valid SHALL be 0.

Structure
REQ-031 The counter encoding (SNT=0, WNT=1, WT=2, ST=3) and the mispred_cnt width SHALL be defined in the shared core package.
REQ-032 The 2-bit saturating counter update SHALL be one sub-module, sat_counter2, instantiated per entry.
REQ-033 Table storage SHALL be flops (no SRAM macro), so that single-cycle reset is possible.

Verification
REQ-034 After reset, a lookup of pc=0x100 SHALL give pred_valid=1, pred_taken=0, pred_target=0.
REQ-035 An update with pc=0x100, taken=1, target=0x80 followed by a lookup of 0x100 SHALL give taken=1, target=0x80.
REQ-036 Two not-taken updates of 0x100 after REQ-035 SHALL make a lookup give taken=0 (counter 2->1->0); a further not-taken update SHALL keep the counter at 0.
REQ-037 With ENTRIES=64, an update of pc=0x1100 (same index, different tag) taken SHALL replace the entry, and a lookup of 0x100 SHALL then miss.
REQ-038 A same-cycle lookup and taken update of a cold pc=0x200 SHALL give taken=0 for that lookup; the next lookup SHALL give taken=1.
REQ-039 Three updates with taken != pred_taken SHALL give three mispredict pulses and mispred_cnt=3; a reset SHALL then clear mispred_cnt to 0.
